alu_share_arbiter: RTL



---
 rtl/alu_share_pkg.sv | 19 +
 rtl/alu_share_arbiter_rr_arb2.sv | 16 +
 rtl/alu_share_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_share_pkg;

   localparam int NREQ = 2;

   typedef enum logic [1:0] {
      ADD   = 2'b00,
      AND   = 2'b01,
      NOT   = 2'b10,
      PASSA = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant; the previous winner is held by the parent.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      // On contention the requester that did not win last time goes first.
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters: accept, issue for
// one cycle with registered operands, then hold the result until the owner takes it.
module alu_share_arbiter
   import alu_share_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [2*NREQ-1:0]     req_aluk,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [1:0]            alu_aluk,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   input  logic [WIDTH-1:0]      alu_out,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  busy,
   output logic [CNT_W-1:0]      op_count,
   output logic [1:0]            state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both
   // high. req_ready is only offered in IDLE; rsp_valid is held until the owner's
   // rsp_ready, and the other requester's rsp_ready has no effect.

   arb_state_t          state_q;
   logic                last_q;
   logic                id_q;
   alu_op_t             aluk_q;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;
   logic [WIDTH-1:0]    rsp_data_q;
   logic [NREQ-1:0]     rsp_valid_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;

   logic [1:0]          grant;
   logic                sel;
   logic [1:0]          sel_aluk;
   logic [WIDTH-1:0]    sel_a;
   logic [WIDTH-1:0]    sel_b;
   logic                accept;

   rr_arb2 u_rr_arb2 (
      .req   (req_valid),
      .last  (last_q),
      .grant (grant)
   );

   assign sel      = grant[1];
   assign sel_aluk = sel ? req_aluk[3:2] : req_aluk[1:0];
   assign sel_a    = sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
   assign sel_b    = sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
   assign accept   = (state_q == IDLE) && (grant != 2'b00);
   assign cnt_d    = cnt_q + CNT_W'(1);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         id_q        <= 1'b0;
         aluk_q      <= ADD;
         a_q         <= '0;
         b_q         <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  id_q    <= sel;
                  last_q  <= sel;
                  aluk_q  <= alu_op_t'(sel_aluk);
                  a_q     <= sel_a;
                  b_q     <= sel_b;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               rsp_data_q  <= alu_out;
               rsp_valid_q <= id_q ? 2'b10 : 2'b01;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready[id_q]) begin
                  rsp_valid_q <= '0;
                  cnt_q       <= cnt_d;
                  state_q     <= IDLE;
               end
            end
            default: begin
               rsp_valid_q <= '0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = (state_q == IDLE) ? grant : 2'b00;
   assign alu_aluk  = aluk_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != IDLE);
   assign op_count  = cnt_q;
   assign state_dbg = state_q;

endmodule
